// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  // One bundle of every pipeline-register control the controller drives.
  typedef struct packed {
    logic pc_we;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/hz_load_use_det.sv
// Combinational load-use detector: the ID instruction reads a register that
// the load in EX has not yet produced. Register 0 never creates a hazard.
module hz_load_use_det
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rd);
  assign rt_match = id_uses_rt && (id_rt == ex_rd);
  assign load_use = ex_memread && (ex_rd != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX
// redirects and multi-cycle mul/div freezes, plus two performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  output logic             pc_we,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  generate
    if (MD_LATENCY < 2) begin : g_bad_latency
      $error("pipe_hazard_ctrl: MD_LATENCY must be >= 2");
    end
  endgenerate

  hz_state_t        state;
  hz_state_t        state_nxt;
  logic [MDC_W-1:0] md_cnt;
  logic [MDC_W-1:0] md_cnt_nxt;
  logic             load_use;
  logic             redirect_acc;
  hz_ctrl_t         ctrl;

  hz_load_use_det u_load_use_det (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // Freeze = hold IF/ID and ID/EX, bubble into EX/MEM while mul/div occupies EX.
  always_comb begin
    ctrl         = '0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    redirect_acc = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            ctrl.pc_we      = 1'b1;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            redirect_acc    = 1'b1;
          end else if (ex_md_start) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            state_nxt        = MD_WAIT;
            md_cnt_nxt       = MDC_W'(MD_LATENCY - 2);
          end else if (load_use) begin
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else begin
            ctrl.pc_we = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_cnt != '0) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            md_cnt_nxt       = md_cnt - MDC_W'(1);
          end else begin
            ctrl.pc_we = 1'b1;
            state_nxt  = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      md_cnt       <= '0;
      stall_cycles <= '0;
      redirect_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!ctrl.pc_we) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_acc) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign md_busy     = (state == MD_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-indexed behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int L     = 4;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, ex_memread, ex_redirect, ex_md_start;
  logic             pc_we, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles, redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: absolute cycle index and the cycle the last mul/div was accepted.
  int cyc        = 0;
  int md_s       = 0;
  bit md_active  = 0;
  int exp_stall  = 0;
  int exp_redir  = 0;

  typedef enum int {ADVANCE, FLUSH, FREEZE, BUBBLE} act_t;

  pipe_hazard_ctrl #(.MD_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .pc_we        (pc_we),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_stall   (idex_stall),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A redirect while mul/div occupies EX is a protocol violation.
  always @(posedge clk) begin
    if (!reset) assert (!(md_busy && ex_redirect));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_in_wait();
    return md_active && (cyc > md_s) && (cyc <= md_s + L - 1);
  endfunction

  function automatic bit ref_load_use(input logic mr, input logic [4:0] exrd, rs, rt,
                                      input logic urs, urt);
    if (!mr || exrd == 0) return 0;
    return (urs && rs == exrd) || (urt && rt == exrd);
  endfunction

  task automatic drive_idle();
    ex_redirect = 0; ex_md_start = 0; ex_memread = 0; ex_rd = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    check("rst_pc_we", pc_we, 0);
    check("rst_ctrl", {ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_redirect_cnt", redirect_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; md_active = 0; exp_stall = 0; exp_redir = 0;
  endtask

  // Driver + checker for one cycle: drive at negedge, compare before posedge.
  task automatic step(input logic redir, md, mr, input logic [4:0] exrd, rs, rt,
                      input logic urs, urt);
    act_t       act;
    bit         busy;
    logic [5:0] e;
    @(negedge clk);
    ex_redirect = redir; ex_md_start = md; ex_memread = mr; ex_rd = exrd;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    #1;
    busy = model_in_wait();
    if (busy)                   act = (cyc <= md_s + L - 2) ? FREEZE : ADVANCE;
    else if (redir)             act = FLUSH;
    else if (md)                act = FREEZE;
    else if (ref_load_use(mr, exrd, rs, rt, urs, urt)) act = BUBBLE;
    else                        act = ADVANCE;
    if (!busy && !redir && md) begin
      md_active = 1;
      md_s      = cyc;
    end
    // {pc_we, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}
    case (act)
      ADVANCE: e = 6'b100000;
      FLUSH:   e = 6'b101010;
      FREEZE:  e = 6'b010101;
      default: e = 6'b010010;
    endcase
    check("pc_we", pc_we, e[5]);
    check("ifid_stall", ifid_stall, e[4]);
    check("ifid_flush", ifid_flush, e[3]);
    check("idex_stall", idex_stall, e[2]);
    check("idex_flush", idex_flush, e[1]);
    check("exmem_flush", exmem_flush, e[0]);
    check("md_busy", md_busy, busy);
    check("stall_cycles", stall_cycles, exp_stall);
    check("redirect_cnt", redirect_cnt, exp_redir);
    check("ifid_excl", ifid_stall & ifid_flush, 0);
    check("idex_excl", idex_stall & idex_flush, 0);
    if (!e[5]) exp_stall = (exp_stall + 1) % CMOD;
    if (act == FLUSH) exp_redir = (exp_redir + 1) % CMOD;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic peek_counters(input string tag, input int st, input int rc);
    @(negedge clk);
    #1;
    check({tag, "_stall_cycles"}, stall_cycles, st);
    check({tag, "_redirect_cnt"}, redirect_cnt, rc);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a mul/div wait (md counter at 1).
    do_reset();
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    @(negedge clk);
    drive_idle();
    #1;
    reset = 1'b1;
    #1;
    check("midmd_pc_we", pc_we, 0);
    check("midmd_md_busy", md_busy, 0);
    check("midmd_stall_cycles", stall_cycles, 0);
    check("midmd_ctrl", {ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; md_active = 0; exp_stall = 0; exp_redir = 0;
    idle();

    // Load-use on rs, then the load leaves EX; then a load to r0.
    do_reset();
    step(0, 0, 1, 5'd8, 5'd8, 5'd3, 1, 0);
    idle();
    peek_counters("lu", 1, 0);
    step(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step(0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1);
    step(0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 0);

    // Redirect together with load-use.
    do_reset();
    step(1, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
    peek_counters("redir", 0, 1);

    // Mul/div freeze, then back-to-back mul/div after the release cycle.
    do_reset();
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (3) idle();
    peek_counters("md", 3, 0);
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0);
    idle();
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) idle();

    // Stall counter wrap at 2^CNT_W.
    do_reset();
    repeat (17) step(0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
    idle();
    peek_counters("wrap", 1, 0);

    // Random traffic with small register numbers to provoke hazards.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic r, m;
      r = !model_in_wait() && ($urandom_range(0, 5) == 0);
      m = ($urandom_range(0, 7) == 0);
      step(r, m, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
